// File: rtl/lc3_branch_sequencer.sv
// LC-3 multi-cycle control FSM: fetch/decode/execute for ADD/AND/NOT/LDR/BR/JMP/PSE.
// Optional BR_STATS_EN adds branch statistic counters Br_Total/Br_Taken.
module lc3_branch_sequencer #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       Mem_OE,
  output logic [4:0] State_Dbg
`ifdef BR_STATS_EN
  ,
  output logic [15:0] Br_Total,
  output logic [15:0] Br_Taken
`endif
);

  typedef enum logic [4:0] {
    HALTED   = 5'd0,
    FETCH1   = 5'd1,
    FETCH2   = 5'd2,
    FETCH3   = 5'd3,
    DECODE   = 5'd4,
    EXEC_ALU = 5'd5,
    BR_TEST  = 5'd6,
    BR_TAKE  = 5'd7,
    JMP      = 5'd8,
    LDR1     = 5'd9,
    LDR2     = 5'd10,
    LDR3     = 5'd11,
    PAUSE1   = 5'd12,
    PAUSE2   = 5'd13
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt;
  logic       last;

  assign last      = (cnt == 4'(MEM_WAIT - 1));
  assign State_Dbg = state;

  // Wait counter restarts on every state entry and only advances in memory states.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)                    cnt <= '0;
      else if (state == FETCH2 || state == LDR2) cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    state_n    = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    Mem_OE     = 1'b0;
    case (state)
      HALTED: if (Run) state_n = FETCH1;
      FETCH1: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
        state_n = FETCH2;
      end
      FETCH2: begin
        Mem_OE = 1'b1;
        if (last) begin LD_MDR = 1'b1; state_n = FETCH3; end
      end
      FETCH3: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_n = DECODE;
      end
      DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001, 4'b0101, 4'b1001: state_n = EXEC_ALU;
          4'b0000:                   state_n = BR_TEST;
          4'b0110:                   state_n = LDR1;
          4'b1100:                   state_n = JMP;
          4'b1101:                   state_n = PAUSE1;
          default:                   state_n = FETCH1;
        endcase
      end
      EXEC_ALU: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        case (Opcode)
          4'b0101: ALUK = 2'b01;
          4'b1001: ALUK = 2'b10;
          default: ALUK = 2'b00;
        endcase
        state_n = FETCH1;
      end
      BR_TEST: state_n = BEN ? BR_TAKE : FETCH1;
      BR_TAKE: begin
        ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
        state_n = FETCH1;
      end
      JMP: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
        state_n = FETCH1;
      end
      LDR1: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; SR1MUX = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1;
        state_n = LDR2;
      end
      LDR2: begin
        Mem_OE = 1'b1;
        if (last) begin LD_MDR = 1'b1; state_n = LDR3; end
      end
      LDR3: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_n = FETCH1;
      end
      // Two-phase pause so a held Continue cannot run through several pauses.
      PAUSE1: if (Continue)  state_n = PAUSE2;
      PAUSE2: if (!Continue) state_n = FETCH1;
      default: state_n = HALTED;
    endcase
  end

`ifdef BR_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Br_Total <= '0;
      Br_Taken <= '0;
    end else begin
      if (state == BR_TEST) Br_Total <= Br_Total + 16'd1;
      if (state == BR_TAKE) Br_Taken <= Br_Taken + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_branch_sequencer.sv
// Scoreboard bench for lc3_branch_sequencer: per-instruction reference model pushes
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_lc3_branch_sequencer;
  localparam int MW = 2;
  localparam logic [4:0] S_HALT = 5'd0,  S_F1 = 5'd1,   S_F2 = 5'd2,   S_F3 = 5'd3,
                         S_DEC  = 5'd4,  S_ALU = 5'd5,  S_BRT = 5'd6,  S_BRK = 5'd7,
                         S_JMP  = 5'd8,  S_LDR1 = 5'd9, S_LDR2 = 5'd10, S_LDR3 = 5'd11,
                         S_P1   = 5'd12, S_P2 = 5'd13;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE;
  logic [4:0] State_Dbg;
`ifdef BR_STATS_EN
  logic [15:0] Br_Total, Br_Taken;
`endif

  lc3_branch_sequencer #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .Mem_OE(Mem_OE),
    .State_Dbg(State_Dbg)
`ifdef BR_STATS_EN
    , .Br_Total(Br_Total), .Br_Taken(Br_Taken)
`endif
  );

  typedef struct packed {
    logic [4:0] st;
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic drmux, sr1mux, sr2mux, mem_oe;
  } ov_t;

  typedef struct {
    int          cyc;
    ov_t         o;
    logic [15:0] tot;
    logic [15:0] tak;
  } exp_t;

  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [15:0] m_tot = '0, m_tak = '0;
  ov_t act;

  assign act = {State_Dbg, LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                ALUK, DRMUX, SR1MUX, SR2MUX, Mem_OE};

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Monitor: every expected entry is compared in the cycle it was tagged with.
  always @(negedge Clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != cyc || act !== e.o) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, e.cyc, act, e.o);
      end
`ifdef BR_STATS_EN
      n_chk++;
      if (Br_Total !== e.tot || Br_Taken !== e.tak) begin
        n_fail++;
        $display("FAIL br_stats cyc=%0d got=%0d/%0d exp=%0d/%0d",
                 cyc, Br_Total, Br_Taken, e.tot, e.tak);
      end
`endif
    end
  end

  function automatic ov_t mk(input logic [4:0] st);
    mk = '0;
    mk.st = st;
  endfunction

  // Advance one clock and record what the DUT must show during the new cycle.
  task automatic step(input ov_t o);
    logic r;
    r = Reset;
    @(posedge Clk); #1;
    if (r) begin m_tot = '0; m_tak = '0; end
    q.push_back(exp_t'{cyc, o, m_tot, m_tak});
    if (o.st == S_BRT) m_tot++;
    if (o.st == S_BRK) m_tak++;
  endtask

  task automatic fetch1();
    ov_t e;
    e = mk(S_F1); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
    step(e);
  endtask

  task automatic mem_wait(input logic [4:0] st);
    ov_t e;
    for (int i = 0; i < MW; i++) begin
      e = mk(st); e.mem_oe = 1; e.ld_mdr = (i == MW - 1);
      step(e);
    end
  endtask

  // One full instruction starting with the FETCH1 cycle; p/pq = PAUSE1/PAUSE2 dwell.
  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ben,
                           input int p, input int pq);
    ov_t e;
    fetch1();
    Opcode = op; IR_5 = ir5; BEN = ben; Continue = 1'b0; Run = 1'($urandom);
    mem_wait(S_F2);
    e = mk(S_F3); e.gate_mdr = 1; e.ld_ir = 1; step(e);
    e = mk(S_DEC); e.ld_ben = 1; step(e);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        e = mk(S_ALU); e.sr1mux = 1; e.sr2mux = ir5; e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
        e.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        step(e);
      end
      4'b0000: begin
        step(mk(S_BRT));
        if (ben) begin
          e = mk(S_BRK); e.pcmux = 2'b10; e.addr2mux = 2'b10; e.ld_pc = 1; step(e);
        end
      end
      4'b0110: begin
        e = mk(S_LDR1); e.addr1mux = 1; e.addr2mux = 2'b01; e.sr1mux = 1;
        e.gate_marmux = 1; e.ld_mar = 1; step(e);
        mem_wait(S_LDR2);
        e = mk(S_LDR3); e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; step(e);
      end
      4'b1100: begin
        e = mk(S_JMP); e.sr1mux = 1; e.aluk = 2'b11; e.gate_alu = 1;
        e.pcmux = 2'b01; e.ld_pc = 1; step(e);
      end
      4'b1101: begin
        for (int i = 0; i < p; i++) step(mk(S_P1));
        Continue = 1'b1;
        for (int i = 0; i < pq; i++) step(mk(S_P2));
        Continue = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Run = 1'b1; Continue = 1'b0; Opcode = 4'h0; IR_5 = 1'b0; BEN = 1'b0;
    repeat (3) step(mk(S_HALT));
    Reset = 1'b0;
    run_instr(4'b0001, 1'b1, 1'b0, 1, 1);
    run_instr(4'b0000, 1'b0, 1'b1, 1, 1);
    run_instr(4'b0000, 1'b0, 1'b0, 1, 1);
    run_instr(4'b0110, 1'b0, 1'b0, 1, 1);
    run_instr(4'b1100, 1'b1, 1'b1, 1, 1);
    run_instr(4'b1101, 1'b0, 1'b0, 11, 1);
    run_instr(4'b1111, 1'b1, 1'b1, 1, 1);
    run_instr(4'b0101, 1'b0, 1'b0, 1, 1);
    run_instr(4'b1001, 1'b1, 1'b0, 1, 1);
    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 3));
    // Reset while the fetch is waiting on memory.
    begin
      ov_t e;
      fetch1();
      Opcode = 4'b0001;
      e = mk(S_F2); e.mem_oe = 1; e.ld_mdr = (MW == 1); step(e);
      Reset = 1'b1;
      step(mk(S_HALT));
      Reset = 1'b0; Run = 1'b0;
      step(mk(S_HALT));
      step(mk(S_HALT));
      Run = 1'b1;
    end
    run_instr(4'b0000, 1'b0, 1'b1, 1, 1);
    run_instr(4'b0000, 1'b1, 1'b1, 1, 1);
    run_instr(4'b0000, 1'b0, 1'b0, 1, 1);
    for (int n = 0; n < 10; n++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                $urandom_range(1, 3), $urandom_range(1, 2));
    fetch1();
    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
